dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single 256-bit line-based data memory between
//  the instruction cache (r0) and the data cache (r1). It grants the memory port to
//  one requester at a time, round-robin. It forwards the read line and a gated ack
//  to the granted requester. A watchdog aborts a transaction that the memory never acks.
// PARAMETERS
//  ADDR_W       32   address width, both requesters and memory
//  DATA_W       256  cache-line width
//  TIMEOUT_CYC  64   max BUSY cycles without mem_ack_i before abort; 0 disables watchdog
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       reset, asynchronous, active-low
//  r0_enable_i  in   1       requester 0 (icache) request; held until r0_ack_o
//  r0_write_i   in   1       requester 0 write (line write-back)
//  r0_addr_i    in   ADDR_W  requester 0 line address, bits[4:0]=0
//  r0_data_i    in   DATA_W  requester 0 write line
//  r0_data_o    out  DATA_W  read line to requester 0
//  r0_ack_o     out  1       requester 0 completion pulse
//  r1_*         same set as r0_* for requester 1 (dcache)
//  mem_enable_o out  1       memory request
//  mem_write_o  out  1       memory write
//  mem_addr_o   out  ADDR_W  memory address
//  mem_data_o   out  DATA_W  memory write line
//  mem_data_i   in   DATA_W  memory read line
//  mem_ack_i    in   1       memory completion, one-cycle pulse
//  grant_o      out  2       one-hot current grant {r1,r0}; 00 when none
//  timeout_o    out  1       sticky: a watchdog abort has occurred
// BEHAVIOUR
//  - Reset (async, rst_i=0): state IDLE, grant_o=00, last-served pointer=r1 (so r0 wins
//    the first tie), watchdog count=0, timeout_o=0. All mem_* outputs and rN_ack_o are 0.
//  - FSM states:
//    - IDLE: sample enables at the clock edge.
//      - Only one enable set: grant that requester and go to BUSY.
//      - Both set: grant the requester not last served, go to BUSY.
//      - None set: stay in IDLE.
//    - BUSY: mem_enable_o=1. mem_write_o, mem_addr_o and mem_data_o are combinational
//      copies of the granted requester's inputs.
//      - mem_ack_i=1: assert rN_ack_o combinationally for the granted requester only,
//        the same cycle. Update the last-served pointer, go to RELEASE.
//      - Granted rN_enable_i drops with no ack (protocol violation): go to RELEASE,
//        no ack issued, pointer still updated.
//      - Watchdog count reaches TIMEOUT_CYC with no ack: set timeout_o, go to RELEASE,
//        pointer updated. If ack and timeout fall in the same cycle, the ack wins.
//    - RELEASE: exactly one cycle with every mem_* output 0 and grant_o=00, so the
//      memory sees enable low between transactions. Then go to IDLE.
//  - Latency: request at edge t -> mem_enable_o high from t+1. After an ack in cycle a,
//    the next grant's mem_enable_o rises at a+3 (RELEASE a+1, IDLE a+2).
//  - A requester holding enable continuously across back-to-back transactions (dcache
//    write-back then refill) is re-arbitrated like any new request.
//  - rN_data_o = mem_data_i for both requesters at all times. Only the ack is gated.
//  - mem_ack_i outside BUSY is ignored: no rN_ack_o, no state change.
//  - Watchdog: 16-bit counter, cleared on entry to BUSY, +1 per BUSY cycle, saturating.
//  - mem_* outputs are 0 whenever the state is not BUSY. grant_o is registered,
//    one-hot or zero, never 11.
//  - Reset mid-transaction: immediate return to reset values. Any memory ack pending at
//    that point falls outside BUSY and is ignored.
// TESTING
//  - Single read: r0 read 0x0000_0400, memory acks 10 cycles after enable ->
//    r0_ack_o one pulse, r0_data_o = line, r1_ack_o stays 0, RELEASE then IDLE.
//  - Tie: r0 and r1 request in the same cycle after reset -> r0 granted first, then r1.
//    A second simultaneous tie -> r1 first (round-robin).
//  - Back-to-back dcache: r1 write-back to 0x0000_1000, holds enable, switches to read
//    0x0000_2000 -> two grants; mem_enable_o low exactly one cycle between them.
//  - Interleave: r1 requests continuously while r0 requests once -> r0 served no later
//    than after one r1 transaction; no starvation over 100 transactions.
//  - Timeout: TIMEOUT_CYC=8, memory never acks -> after 8 BUSY cycles timeout_o=1 and
//    stays 1. The other pending requester is then granted.
//  - Async reset during BUSY -> outputs 0 immediately; a late mem_ack_i produces no
//    rN_ack_o.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving the icache (r0) and dcache (r1) turns at the shared
// line memory, with ack gating and a BUSY watchdog.
module dmem_arb_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              gnt,
  input  logic              busy,
  input  logic              mem_ack,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              sel_wr,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [DATA_W-1:0] sel_data
);
  logic act;

  // Non-granted requesters contribute zeros, so the memory-side mux is a plain OR.
  assign act      = busy & gnt;
  assign ack      = act & mem_ack;
  assign sel_wr   = act & wr;
  assign sel_addr = {ADDR_W{act}} & addr;
  assign sel_data = {DATA_W{act}} & wdata;
endmodule

module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_data_i,
  output logic [DATA_W-1:0] r0_data_o,
  output logic              r0_ack_o,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_data_i,
  output logic [DATA_W-1:0] r1_data_o,
  output logic              r1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);
  localparam int          NREQ   = 2;
  localparam bit          WD_ON  = (TIMEOUT_CYC != 0);
  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t      state_q, state_nx;
  logic [1:0]  grant_q, grant_nx;
  logic        last_q, last_nx;      // 1: r1 served last
  logic [15:0] wdog_q, wdog_nx;
  logic        timeout_q, timeout_nx;

  logic [NREQ-1:0]             req_en, req_wr, ack;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0]             sel_wr;
  logic [NREQ-1:0][ADDR_W-1:0] sel_addr;
  logic [NREQ-1:0][DATA_W-1:0] sel_data;
  logic                        busy, gnt_en, wd_hit;

  assign req_en   = {r1_enable_i, r0_enable_i};
  assign req_wr   = {r1_write_i,  r0_write_i};
  assign req_addr = {r1_addr_i,   r0_addr_i};
  assign req_data = {r1_data_i,   r0_data_i};

  assign busy   = (state_q == S_BUSY);
  assign gnt_en = |(req_en & grant_q);
  assign wd_hit = WD_ON && (({1'b0, wdog_q} + 17'd1) >= TO_LIM);

  for (genvar i = 0; i < NREQ; i++) begin : g_port
    dmem_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
      .gnt      (grant_q[i]),
      .busy     (busy),
      .mem_ack  (mem_ack_i),
      .wr       (req_wr[i]),
      .addr     (req_addr[i]),
      .wdata    (req_data[i]),
      .ack      (ack[i]),
      .sel_wr   (sel_wr[i]),
      .sel_addr (sel_addr[i]),
      .sel_data (sel_data[i])
    );
  end

  always_comb begin
    state_nx   = state_q;
    grant_nx   = grant_q;
    last_nx    = last_q;
    wdog_nx    = wdog_q;
    timeout_nx = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (|req_en) begin
          state_nx = S_BUSY;
          wdog_nx  = '0;
          if (&req_en) grant_nx = last_q ? 2'b01 : 2'b10;
          else         grant_nx = req_en;
        end
      end
      S_BUSY: begin
        wdog_nx = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
        // Ack beats both an enable drop and the watchdog in the same cycle.
        if (mem_ack_i || !gnt_en || wd_hit) begin
          state_nx = S_RELEASE;
          grant_nx = 2'b00;
          last_nx  = grant_q[1];
          if (!mem_ack_i && gnt_en) timeout_nx = 1'b1;
        end
      end
      S_RELEASE: state_nx = S_IDLE;
      default: begin
        state_nx = S_IDLE;
        grant_nx = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nx;
      grant_q   <= grant_nx;
      last_q    <= last_nx;
      wdog_q    <= wdog_nx;
      timeout_q <= timeout_nx;
    end
  end

  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    for (int i = 0; i < NREQ; i++) begin
      mem_write_o = mem_write_o | sel_wr[i];
      mem_addr_o  = mem_addr_o  | sel_addr[i];
      mem_data_o  = mem_data_o  | sel_data[i];
    end
  end

  assign mem_enable_o = busy;
  assign r0_ack_o     = ack[0];
  assign r1_ack_o     = ack[1];
  assign r0_data_o    = mem_data_i;
  assign r1_data_o    = mem_data_i;
  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single transactions, directed multi-cycle
// sequences, then random traffic against a transaction-level reference model.
module tb_dmem_arbiter;
  logic         clk = 1'b0, rst = 1'b0;
  logic         r0_en = 0, r0_wr = 0, r1_en = 0, r1_wr = 0, mem_ack = 0;
  logic [31:0]  r0_addr = 0, r1_addr = 0;
  logic [255:0] r0_wd = 0, r1_wd = 0, mem_rd = 0;

  logic [255:0] r0_rd, r1_rd, mem_wd, w_r0_rd, w_r1_rd, w_mem_wd;
  logic         r0_ack, r1_ack, mem_en, mem_wr, timeout;
  logic         w_r0_ack, w_r1_ack, w_mem_en, w_mem_wr, w_timeout;
  logic [31:0]  mem_addr, w_mem_addr;
  logic [1:0]   grant, w_grant;

  int n_chk = 0, n_pass = 0;

  dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .r0_enable_i(r0_en), .r0_write_i(r0_wr), .r0_addr_i(r0_addr), .r0_data_i(r0_wd),
    .r0_data_o(r0_rd), .r0_ack_o(r0_ack),
    .r1_enable_i(r1_en), .r1_write_i(r1_wr), .r1_addr_i(r1_addr), .r1_data_i(r1_wd),
    .r1_data_o(r1_rd), .r1_ack_o(r1_ack),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wd), .mem_data_i(mem_rd), .mem_ack_i(mem_ack),
    .grant_o(grant), .timeout_o(timeout));

  dmem_arbiter #(.TIMEOUT_CYC(8)) dut_w (
    .clk_i(clk), .rst_i(rst),
    .r0_enable_i(r0_en), .r0_write_i(r0_wr), .r0_addr_i(r0_addr), .r0_data_i(r0_wd),
    .r0_data_o(w_r0_rd), .r0_ack_o(w_r0_ack),
    .r1_enable_i(r1_en), .r1_write_i(r1_wr), .r1_addr_i(r1_addr), .r1_data_i(r1_wd),
    .r1_data_o(w_r1_rd), .r1_ack_o(w_r1_ack),
    .mem_enable_o(w_mem_en), .mem_write_o(w_mem_wr), .mem_addr_o(w_mem_addr),
    .mem_data_o(w_mem_wd), .mem_data_i(mem_rd), .mem_ack_i(mem_ack),
    .grant_o(w_grant), .timeout_o(w_timeout));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    r0_en = 0; r1_en = 0; r0_wr = 0; r1_wr = 0; mem_ack = 0;
    r0_addr = 0; r1_addr = 0; r0_wd = 0; r1_wd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    step(); step();
    chk("rst_grant", grant, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_w_timeout", w_timeout, 0);
    rst = 1;
  endtask

  typedef struct {
    logic        en0, en1, wr0, wr1;
    logic [31:0] a0, a1;
    int          lat;       // BUSY cycles before the ack cycle
    logic [1:0]  exp_gnt;
  } vec_t;

  vec_t tbl[8];

  task automatic run_vec(input vec_t v, input int idx);
    logic [255:0] rd;
    logic [31:0]  ea;
    logic         ew;
    logic [255:0] ed;
    r0_en = v.en0; r1_en = v.en1; r0_wr = v.wr0; r1_wr = v.wr1;
    r0_addr = v.a0; r1_addr = v.a1;
    r0_wd = {8{v.a0 ^ 32'hA5A5_0000}}; r1_wd = {8{v.a1 ^ 32'h5A5A_0000}};
    ea = v.exp_gnt[1] ? v.a1 : v.a0;
    ew = v.exp_gnt[1] ? v.wr1 : v.wr0;
    ed = v.exp_gnt[1] ? r1_wd : r0_wd;
    step();
    chk($sformatf("v%0d_grant", idx), grant, v.exp_gnt);
    chk($sformatf("v%0d_mem_en", idx), mem_en, 1);
    chk($sformatf("v%0d_addr", idx), mem_addr, ea);
    chk($sformatf("v%0d_wr", idx), mem_wr, ew);
    chk($sformatf("v%0d_wdata", idx), mem_wd, ed);
    for (int i = 0; i < v.lat; i++) begin
      chk($sformatf("v%0d_noack", idx), {r1_ack, r0_ack, mem_en}, 3'b001);
      step();
    end
    rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    mem_rd = rd; mem_ack = 1; #1;
    chk($sformatf("v%0d_ack", idx), {r1_ack, r0_ack}, v.exp_gnt);
    chk($sformatf("v%0d_rdata0", idx), r0_rd, rd);
    chk($sformatf("v%0d_rdata1", idx), r1_rd, rd);
    step();
    clear_inputs(); #1;
    chk($sformatf("v%0d_release", idx), {grant, mem_en, mem_addr}, 0);
    step();
    chk($sformatf("v%0d_idle", idx), mem_en, 0);
  endtask

  // random-phase model state
  int           phase, g, last, cd, txns;
  logic [1:0]   en, wr;
  logic [31:0]  ad[2];
  logic [255:0] wd[2];
  int           wait_c[2], max_wait[2], served[2];
  logic         ack_r;
  logic [255:0] rd_r;

  initial begin
    int cnt;
    tbl[0] = '{1, 1, 0, 0, 32'h0000_0100, 32'h0000_0200, 2,  2'b01};
    tbl[1] = '{1, 1, 0, 1, 32'h0000_0120, 32'h0000_0220, 0,  2'b10};
    tbl[2] = '{1, 0, 0, 0, 32'h0000_0400, 32'h0,         10, 2'b01};
    tbl[3] = '{1, 1, 1, 0, 32'h0000_0500, 32'h0000_0600, 1,  2'b10};
    tbl[4] = '{0, 1, 0, 1, 32'h0,         32'h0000_0740, 3,  2'b10};
    tbl[5] = '{1, 1, 0, 0, 32'h0000_0860, 32'h0000_0880, 0,  2'b01};
    tbl[6] = '{1, 0, 1, 0, 32'h0000_09E0, 32'h0,         4,  2'b01};
    tbl[7] = '{1, 1, 0, 0, 32'hFFFF_FFE0, 32'h8000_0000, 2,  2'b10};

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // dcache write-back then refill with enable held throughout
    r1_en = 1; r1_wr = 1; r1_addr = 32'h0000_1000; r1_wd = {8{32'hDEAD_BEEF}};
    step();
    chk("b2b_grant1", grant, 2'b10);
    chk("b2b_wr1", {mem_wr, mem_addr}, {1'b1, 32'h0000_1000});
    mem_ack = 1; #1;
    chk("b2b_ack1", {r1_ack, r0_ack}, 2'b10);
    step();
    mem_ack = 0; r1_wr = 0; r1_addr = 32'h0000_2000; #1;
    chk("b2b_gap_a1", mem_en, 0);
    step();
    chk("b2b_gap_a2", mem_en, 0);
    step();
    chk("b2b_grant2", {grant, mem_en}, 3'b101);
    chk("b2b_rd2", {mem_wr, mem_addr}, {1'b0, 32'h0000_2000});
    mem_ack = 1; #1;
    chk("b2b_ack2", r1_ack, 1);
    step(); clear_inputs(); step();

    // granted requester drops enable without ack
    r0_en = 1; r0_addr = 32'h0000_0C00;
    step();
    chk("drop_grant", grant, 2'b01);
    step();
    r0_en = 0; #1;
    chk("drop_noack", r0_ack, 0);
    step();
    chk("drop_release", {grant, mem_en}, 0);
    chk("drop_no_timeout", timeout, 0);
    step();
    r0_en = 1; r1_en = 1; r1_addr = 32'h0000_0D00;
    step();
    chk("drop_ptr_moved", grant, 2'b10);
    mem_ack = 1; step(); clear_inputs(); step();

    // async reset while BUSY, then a late ack
    r0_en = 1; r0_addr = 32'h0000_0E00;
    step();
    chk("arst_busy", mem_en, 1);
    #3 rst = 0; #1;
    chk("arst_outputs", {grant, mem_en, mem_wr, mem_addr}, 0);
    mem_ack = 1; #1;
    chk("arst_ack_in_reset", r0_ack, 0);
    r0_en = 0;
    step(); step();
    rst = 1; #1;
    chk("arst_late_ack", {r0_ack, r1_ack, mem_en}, 0);
    step();
    chk("arst_ack_ignored", {r0_ack, mem_en, grant}, 0);
    mem_ack = 0;

    // watchdog on the TIMEOUT_CYC=8 instance
    do_reset();
    r0_en = 1; r0_addr = 32'h0000_3000; r1_en = 1; r1_addr = 32'h0000_4000;
    step();
    cnt = 0;
    for (int k = 0; k < 40 && w_mem_en; k++) begin
      cnt++; step();
    end
    chk("wd_busy_cycles", cnt, 8);
    chk("wd_timeout_set", w_timeout, 1);
    chk("wd_release", w_grant, 0);
    step();
    chk("wd_idle", w_mem_en, 0);
    step();
    chk("wd_other_grant", w_grant, 2'b10);
    chk("wd_other_addr", w_mem_addr, 32'h0000_4000);
    mem_ack = 1; #1;
    chk("wd_other_ack", {w_r1_ack, w_r0_ack}, 2'b10);
    step();
    mem_ack = 0; r1_en = 0; r0_en = 0;
    step(); step(); step();
    chk("wd_sticky", w_timeout, 1);

    // random traffic vs. transaction-level model
    do_reset();
    phase = 0; last = 1; txns = 0; en = 0; wr = 0; g = 0; cd = 0;
    for (int i = 0; i < 2; i++) begin
      wait_c[i] = 0; max_wait[i] = 0; served[i] = 0; ad[i] = 0; wd[i] = 0;
    end
    for (int cyc = 0; cyc < 4000 && txns < 100; cyc++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (!en[i] && $urandom_range(0, 3) == 0) begin
          en[i] = 1; wr[i] = 1'($urandom);
          ad[i] = $urandom & 32'hFFFF_FFE0;
          wd[i] = {8{$urandom}};
        end
      ack_r = (phase == 1) ? (cd == 0) : ($urandom_range(0, 4) == 0);
      rd_r  = {8{$urandom}};
      r0_en = en[0]; r0_wr = wr[0]; r0_addr = ad[0]; r0_wd = wd[0];
      r1_en = en[1]; r1_wr = wr[1]; r1_addr = ad[1]; r1_wd = wd[1];
      mem_ack = ack_r; mem_rd = rd_r;
      #1;
      chk("rnd_grant", grant, phase == 1 ? (g == 1 ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd_mem_en", mem_en, phase == 1);
      chk("rnd_mem_req", {mem_wr, mem_addr, mem_wd},
          phase == 1 ? {wr[g], ad[g], wd[g]} : 289'd0);
      chk("rnd_acks", {r1_ack, r0_ack},
          {phase == 1 && g == 1 && ack_r, phase == 1 && g == 0 && ack_r});
      chk("rnd_rdata", {r1_rd, r0_rd}, {rd_r, rd_r});
      chk("rnd_timeout", timeout, 0);
      for (int i = 0; i < 2; i++) begin
        if (en[i] && !(phase == 1 && g == i)) wait_c[i]++;
        if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
      end
      case (phase)
        1: if (ack_r) begin
             last = g; served[g]++; en[g] = 0; wait_c[g] = 0; txns++; phase = 2;
           end else cd--;
        2: phase = 0;
        default: if (en != 0) begin
             g = (en == 2'b11) ? (last == 1 ? 0 : 1) : (en[1] ? 1 : 0);
             cd = $urandom_range(0, 5); phase = 1;
           end
      endcase
    end
    chk("rnd_txn_count", txns, 100);
    chk("rnd_r0_fair", max_wait[0] <= 12, 1);
    chk("rnd_r1_fair", max_wait[1] <= 12, 1);
    chk("rnd_both_served", served[0] > 10 && served[1] > 10, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
